msg_padder: RTL and testbench

Upstream stage of the hash datapath: collects message bytes as they return from message memory, then builds the single SHA-256 512-bit padded block that W-generation loads into its 16-word window. Padding appends 0x80, zero fill and a 64-bit big-endian bit-length. Messages are limited to one block (at most 55 bytes).

---
 rtl/sha256_pkg.sv | 17 +
 rtl/msg_padder.sv | 159 +++++++++++++++
 tb/tb_msg_padder.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message padding stage.
package sha256_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StPad,
    StHold
  } pad_state_e;

  localparam int unsigned BLOCK_BYTES       = 64;
  localparam int unsigned LEN_FIELD_BYTES   = 8;
  localparam int unsigned MAX_PAD_MSG_BYTES = 55;

  localparam logic [7:0] PAD_BYTE = 8'h80;

endpackage

// File: rtl/msg_padder.sv
// Collects message bytes and builds the single padded SHA-256 block (0x80, zero fill,
// 64-bit big-endian bit length) for W-generation.
module msg_padder
  import sha256_pkg::*;
#(
  parameter int unsigned MAX_MESSAGE_LENGTH = MAX_PAD_MSG_BYTES,
  parameter int unsigned BLOCK_WIDTH        = BLOCK_BYTES * 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [$clog2(MAX_MESSAGE_LENGTH):0]   msg_length,
  input  logic [7:0]                            msg_data,
  input  logic                                  msg_valid,
  input  logic                                  block_ack,
  output logic [BLOCK_WIDTH-1:0]                block,
  output logic                                  block_valid,
  output logic                                  busy,
  output logic                                  len_err
);

  localparam int unsigned LenW      = $clog2(MAX_MESSAGE_LENGTH) + 1;
  localparam int unsigned PosW      = $clog2(BLOCK_WIDTH);
  localparam int unsigned LenFieldW = LEN_FIELD_BYTES * 8;
  localparam logic [LenW-1:0] MaxLen = LenW'(MAX_MESSAGE_LENGTH);

  pad_state_e state_q, state_d;

  logic [BLOCK_WIDTH-1:0] block_q, block_d;
  logic [LenW-1:0]        idx_q, idx_d;
  logic [LenW-1:0]        len_q, len_d;
  logic                   len_err_q, len_err_d;

  logic            len_bad;
  logic            last_byte;
  logic [LenW-1:0] wr_byte;
  logic [PosW-1:0] wr_pos;

  assign len_bad   = msg_length > MaxLen;
  assign last_byte = msg_valid && ((idx_q + LenW'(1)) == len_q);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start && !len_bad) begin
          state_d = (msg_length == '0) ? StPad : StLoad;
        end
      end
      StLoad: begin
        if (last_byte) begin
          state_d = StPad;
        end
      end
      StPad: begin
        state_d = StHold;
      end
      StHold: begin
        if (block_ack) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy        = 1'b0;
    block_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StLoad, StPad: begin
        busy = 1'b1;
      end
      StHold: begin
        busy        = 1'b1;
        block_valid = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // One byte write port: message bytes in LOAD, the pad marker at index len in PAD.
  always_comb begin
    wr_byte = (state_q == StPad) ? len_q : idx_q;
    wr_pos  = PosW'(BLOCK_WIDTH - 8 - 8 * int'(wr_byte));
  end

  always_comb begin
    block_d   = block_q;
    idx_d     = idx_q;
    len_d     = len_q;
    len_err_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (len_bad) begin
            len_err_d = 1'b1;
          end else begin
            len_d   = msg_length;
            idx_d   = '0;
            block_d = '0;
          end
        end
      end
      StLoad: begin
        if (msg_valid) begin
          block_d[wr_pos +: 8] = msg_data;
          idx_d                = idx_q + LenW'(1);
        end
      end
      StPad: begin
        block_d[wr_pos +: 8]       = PAD_BYTE;
        block_d[LenFieldW-1:0]     = LenFieldW'({len_q, 3'b000});
      end
      StHold: begin
        block_d = block_q;
      end
      default: begin
        block_d = block_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      block_q   <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      block_q   <= block_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      len_err_q <= len_err_d;
    end
  end

  assign block   = block_q;
  assign len_err = len_err_q;

endmodule

// File: tb/tb_msg_padder.sv
// Randomized scoreboard bench for msg_padder against a byte-array padding model.
module tb_msg_padder;

  logic         clk;
  logic         reset;
  logic         start;
  logic [6:0]   msg_length;
  logic [7:0]   msg_data;
  logic         msg_valid;
  logic         block_ack;
  logic [511:0] block;
  logic         block_valid;
  logic         busy;
  logic         len_err;

  msg_padder dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .msg_length (msg_length),
    .msg_data   (msg_data),
    .msg_valid  (msg_valid),
    .block_ack  (block_ack),
    .block      (block),
    .block_valid(block_valid),
    .busy       (busy),
    .len_err    (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [511:0] blk;
    int           lat;
  } exp_t;

  exp_t         exp_q[$];
  logic [511:0] last_exp;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           start_edge = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Padded block from the padding rules: message, 0x80, zeros, 64-bit big-endian bit count.
  function automatic logic [511:0] model(input logic [7:0] m[$]);
    logic [7:0]   b[64];
    logic [63:0]  bits;
    logic [511:0] r;
    int           n;
    n = m.size();
    for (int i = 0; i < 64; i++) b[i] = 8'h00;
    for (int i = 0; i < n; i++) b[i] = m[i];
    b[n] = 8'h80;
    bits = 64'(n) * 64'd8;
    for (int i = 0; i < 8; i++) b[56 + i] = bits[63 - 8 * i -: 8];
    r = '0;
    for (int i = 0; i < 64; i++) r = {r[503:0], b[i]};
    return r;
  endfunction

  // Monitor: pop on each rising block_valid, and hold the block stable while valid.
  initial begin
    exp_t cur;
    logic prev;
    logic have;
    prev = 1'b0;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (block_valid && !prev) begin
        if (exp_q.size() == 0) begin
          chk("valid_without_expect", block_valid, 0);
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          chk("block", block, cur.blk);
          if (cur.lat >= 0) chk("latency", cyc - start_edge, cur.lat);
        end
      end else if (block_valid && have) begin
        chk("block_stable", block, cur.blk);
      end
      prev = block_valid;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last driven byte.
  task automatic send_msg(input logic [7:0] m[$], input int gap_pct, input int over);
    exp_t e;
    e.blk = model(m);
    e.lat = (gap_pct == 0) ? m.size() + 1 : -1;
    exp_q.push_back(e);
    last_exp   = e.blk;
    start      = 1'b1;
    msg_length = 7'(m.size());
    @(posedge clk); #1;
    start_edge = cyc;
    start      = 1'b0;
    chk("busy_after_start", busy, 1);
    if (m.size() == 0) begin
      for (int i = 0; i < 3; i++) begin
        msg_valid = 1'b1;
        msg_data  = 8'($urandom);
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < m.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        msg_valid = 1'b0;
        msg_data  = 8'($urandom);
        @(posedge clk); #1;
      end
      msg_valid = 1'b1;
      msg_data  = m[i];
      @(posedge clk); #1;
    end
    for (int i = 0; i < over; i++) begin
      msg_valid = 1'b1;
      msg_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 300 && !block_valid; i++) @(negedge clk);
    chk("valid_timeout", block_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic do_ack();
    wait_valid();
    block_ack = 1'b1;
    @(posedge clk); #1;
    block_ack = 1'b0;
    chk("valid_after_ack", block_valid, 0);
    chk("busy_after_ack", busy, 0);
  endtask

  initial begin
    logic [7:0] m[$];
    reset      = 1'b0;
    start      = 1'b0;
    msg_length = '0;
    msg_data   = '0;
    msg_valid  = 1'b0;
    block_ack  = 1'b0;
    last_exp   = '0;
    @(negedge clk);
    chk("reset_block", block, 0);
    chk("reset_valid", block_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_len_err", len_err, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // "abc", one byte per cycle
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 0);
    do_ack();

    // zero length with stray msg_valid pulses
    m = {};
    send_msg(m, 0, 0);
    do_ack();

    // 55 x 0x41 with gaps and two over-read bytes
    m = {};
    for (int i = 0; i < 55; i++) m.push_back(8'h41);
    send_msg(m, 40, 2);
    do_ack();

    // over-long length
    start      = 1'b1;
    msg_length = 7'd56;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len_err_pulse", len_err, 1);
    chk("len_err_busy", busy, 0);
    @(posedge clk); #1;
    chk("len_err_one_cycle", len_err, 0);
    chk("len_err_block_kept", block, last_exp);
    chk("len_err_still_idle", busy, 0);

    // reset after 2 of 5 bytes
    start      = 1'b1;
    msg_length = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      msg_valid = 1'b1;
      msg_data  = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    msg_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_reset_block", block, 0);
    chk("mid_reset_valid", block_valid, 0);
    chk("mid_reset_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 5; i++) @(posedge clk);
    #1;
    chk("post_reset_valid", block_valid, 0);
    m = '{8'h61, 8'h62, 8'h63};
    send_msg(m, 0, 0);
    wait_valid();

    // HOLD: stray start ignored, then ack together with start, then start next cycle
    start      = 1'b1;
    msg_length = 7'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold_start_valid", block_valid, 1);
    chk("hold_start_block", block, last_exp);
    block_ack  = 1'b1;
    start      = 1'b1;
    msg_length = 7'd3;
    @(posedge clk); #1;
    block_ack = 1'b0;
    start     = 1'b0;
    chk("ack_valid_drop", block_valid, 0);
    chk("ack_start_ignored", busy, 0);
    m = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_msg(m, 0, 1);
    do_ack();

    // random messages
    for (int t = 0; t < 8; t++) begin
      int n;
      n = int'($urandom_range(1, 55));
      m = {};
      for (int i = 0; i < n; i++) m.push_back(8'($urandom));
      send_msg(m, 30, int'($urandom_range(0, 2)));
      do_ack();
    end

    repeat (3) @(posedge clk);
    #1;
    chk("pending_expected", 512'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
